painterengine_gpu_reader: RTL

- Memory-read DMA engine that answers the renderer's reader-controller handshake: address, length, level enable in; done and error out.
- On each enable it fetches a run of 32-bit pixels from memory over an AXI4 read-master subset and pushes them in order into a pixel FIFO.
- One instance per source channel; the renderer's two reader channels each drive one instance.

---
 rtl/painterengine_gpu_pkg.sv | 19 +
 rtl/painterengine_gpu_burst_calc.sv | 22 ++
 rtl/painterengine_gpu_reader.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/painterengine_gpu_pkg.sv
// Shared definitions for the painterengine GPU memory movers (reader now, writer later).
// State encoding is exported on o_wire_state, so the numeric values are fixed.
package painterengine_gpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4,
    ST_FLUSH = 3'd5
  } state_t;

  localparam logic [2:0]  SIZE_4B     = 3'b010;
  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [12:0] BOUNDARY_4K = 13'd4096;

endpackage

// File: rtl/painterengine_gpu_burst_calc.sv
// Beat count for the next burst: min(remaining, MAX_BURST, words left in the 4 KB page).
// Purely combinational; the address must be word aligned.
module painterengine_gpu_burst_calc
  import painterengine_gpu_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic [31:0] i_wire_remaining,
  input  logic [11:0] i_wire_addr_lo,
  output logic [8:0]  o_wire_beats
);

  localparam logic [12:0] MAX_B = 13'(MAX_BURST);

  logic [12:0] w_to_boundary;
  logic [8:0]  w_cap;

  assign w_to_boundary = (BOUNDARY_4K - {1'b0, i_wire_addr_lo}) >> 2;
  assign w_cap         = (w_to_boundary < MAX_B) ? w_to_boundary[8:0] : MAX_B[8:0];
  assign o_wire_beats  = ({23'd0, w_cap} > i_wire_remaining) ? i_wire_remaining[8:0] : w_cap;

endmodule

// File: rtl/painterengine_gpu_reader.sv
// AXI4 read DMA: fetches i_wire_length words into the pixel FIFO, one burst outstanding.
// Data passes to the FIFO combinationally; rready follows !fifo_full while data is kept.
module painterengine_gpu_reader #(
  parameter int MAX_BURST = 16,
  parameter int ID_WIDTH  = 1
) (
  input  logic                i_wire_clock,
  input  logic                i_wire_reset,
  input  logic                i_wire_enable,
  input  logic [31:0]         i_wire_address,
  input  logic [31:0]         i_wire_length,
  output logic                o_wire_done,
  output logic                o_wire_error,
  output logic [31:0]         o_wire_araddr,
  output logic [7:0]          o_wire_arlen,
  output logic [2:0]          o_wire_arsize,
  output logic [1:0]          o_wire_arburst,
  output logic [ID_WIDTH-1:0] o_wire_arid,
  output logic                o_wire_arvalid,
  input  logic                i_wire_arready,
  input  logic [31:0]         i_wire_rdata,
  input  logic [1:0]          i_wire_rresp,
  input  logic                i_wire_rlast,
  input  logic                i_wire_rvalid,
  output logic                o_wire_rready,
  output logic [31:0]         o_wire_fifo_data,
  output logic                o_wire_fifo_write,
  input  logic                i_wire_fifo_full,
  output logic [31:0]         o_wire_state
);
  import painterengine_gpu_pkg::*;

  state_t      r_state, w_next;
  logic [31:0] r_addr, r_remaining;
  logic [8:0]  r_cnt;
  logic        r_err;

  logic [8:0]  w_beats;
  logic [9:0]  w_cnt_nxt;
  logic        w_rready, w_hs, w_write, w_beat_err, w_len_ok;
  logic        w_arvalid, w_done, w_error;

  painterengine_gpu_burst_calc #(.MAX_BURST(MAX_BURST)) u_burst_calc (
    .i_wire_remaining (r_remaining),
    .i_wire_addr_lo   (r_addr[11:0]),
    .o_wire_beats     (w_beats)
  );

  // Once a burst has gone bad its tail is drained without backpressure.
  assign w_rready   = (r_state == ST_DATA) ? (r_err || !i_wire_fifo_full) : (r_state == ST_FLUSH);
  assign w_hs       = i_wire_rvalid && w_rready;
  assign w_write    = (r_state == ST_DATA) && w_hs && !r_err;
  assign w_beat_err = (i_wire_rresp != RESP_OKAY);
  assign w_cnt_nxt  = {1'b0, r_cnt} + 10'd1;
  assign w_len_ok   = (w_cnt_nxt == {1'b0, w_beats});

  always_comb begin
    w_next    = r_state;
    w_arvalid = 1'b0;
    w_done    = 1'b0;
    w_error   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_wire_enable) begin
          if (i_wire_address[1:0] != 2'b00) w_next = ST_ERROR;
          else if (i_wire_length == 32'd0)  w_next = ST_DONE;
          else                              w_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        w_arvalid = 1'b1;
        if (i_wire_arready) w_next = i_wire_enable ? ST_DATA : ST_FLUSH;
      end
      ST_DATA: begin
        if (w_hs && i_wire_rlast) begin
          if (!i_wire_enable)                         w_next = ST_IDLE;
          else if (r_err || w_beat_err || !w_len_ok)  w_next = ST_ERROR;
          else if (r_remaining == {23'd0, w_beats})   w_next = ST_DONE;
          else                                        w_next = ST_ADDR;
        end else if (!i_wire_enable) begin
          w_next = ST_FLUSH;
        end
      end
      ST_DONE: begin
        w_done = 1'b1;
        if (!i_wire_enable) w_next = ST_IDLE;
      end
      ST_ERROR: begin
        w_error = 1'b1;
        if (!i_wire_enable) w_next = ST_IDLE;
      end
      ST_FLUSH: begin
        if (w_hs && i_wire_rlast) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
    if (i_wire_reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && i_wire_enable) begin
        r_addr      <= i_wire_address;
        r_remaining <= i_wire_length;
      end
      if (w_arvalid && i_wire_arready) begin
        r_cnt <= '0;
        r_err <= 1'b0;
      end
      if (r_state == ST_DATA && w_hs) begin
        r_cnt <= w_cnt_nxt[8:0];
        // A missing rlast on the expected final beat poisons the rest of the burst.
        if (w_beat_err || (!i_wire_rlast && w_cnt_nxt >= {1'b0, w_beats})) r_err <= 1'b1;
        if (i_wire_rlast && !r_err && !w_beat_err && w_len_ok) begin
          r_addr      <= r_addr + {21'd0, w_beats, 2'b00};
          r_remaining <= r_remaining - {23'd0, w_beats};
        end
      end
    end
  end

  assign o_wire_done       = w_done;
  assign o_wire_error      = w_error;
  assign o_wire_arvalid    = w_arvalid;
  assign o_wire_araddr     = w_arvalid ? r_addr : 32'd0;
  assign o_wire_arlen      = w_arvalid ? 8'(w_beats - 9'd1) : 8'd0;
  assign o_wire_arsize     = SIZE_4B;
  assign o_wire_arburst    = BURST_INCR;
  assign o_wire_arid       = '0;
  assign o_wire_rready     = w_rready;
  assign o_wire_fifo_write = w_write;
  assign o_wire_fifo_data  = w_write ? i_wire_rdata : 32'd0;
  assign o_wire_state      = {29'd0, r_state};

endmodule
